// File: rtl/instr_sequencer.sv
// MSP430 main control sequencer: steps each instruction through fetch, operand
// index/read, execute and writeback, and handles reset-vector load and interrupt entry.
module instr_sequencer #(
    parameter logic [15:0] RST_VEC = 16'hFFFE,
    parameter logic [15:0] INT_VEC = 16'hFFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] MDB,
    input  logic        IntReq,
    input  logic        NMI,
    input  logic        GIE,
    input  logic        JmpTaken,
    input  logic [15:0] VecAddr,
    output logic [15:0] IW,
    output logic        IF,
    output logic        IdxF,
    output logic        SPF,
    output logic        INTACK,
    output logic        Ex,
    output logic        srcInc,
    output logic        dstInc,
    output logic        RW,
    output logic        SpSel,
    output logic        MemRd,
    output logic        MemWr,
    output logic [2:0]  MabSel,
    output logic [15:0] Vector,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        ST_RSTV    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_SRC_IDX = 4'd2,
        ST_SRC_RD  = 4'd3,
        ST_DST_IDX = 4'd4,
        ST_DST_RD  = 4'd5,
        ST_EXEC    = 4'd6,
        ST_WB_MEM  = 4'd7,
        ST_PUSH    = 4'd8,
        ST_EXEC2   = 4'd9,
        ST_POP_SR  = 4'd10,
        ST_POP_PC  = 4'd11,
        ST_INT_PC  = 4'd12,
        ST_INT_SR  = 4'd13,
        ST_INT_VEC = 4'd14
    } state_t;

    state_t      state_r;
    state_t      next_s;
    logic [15:0] iw_r;

    // The next-state decision in FETCH must see the word on the bus, not the stale IW.
    logic [15:0] instr_s;
    logic        fmt1_s, fmt2_s, jmp_s, cg_s, cmpbit_s, has_src_s;
    logic        dst_mem_s, wb_s, irq_s;
    logic [1:0]  as_s;
    logic [2:0]  op2_s;
    logic [3:0]  op1_s, sreg_s;
    logic        unused_bw_s;

    assign instr_s     = (state_r == ST_FETCH) ? MDB : iw_r;
    assign op1_s       = instr_s[15:12];
    assign op2_s       = instr_s[9:7];
    assign as_s        = instr_s[5:4];
    assign fmt1_s      = (instr_s[15:12] >= 4'd4);
    assign fmt2_s      = (instr_s[15:10] == 6'b000100);
    assign jmp_s       = (instr_s[15:13] == 3'b001);
    assign sreg_s      = fmt1_s ? instr_s[11:8] : instr_s[3:0];
    assign cg_s        = (sreg_s == 4'd3) || ((sreg_s == 4'd2) && (as_s >= 2'd2));
    assign has_src_s   = (fmt1_s || fmt2_s) && !cg_s;
    assign cmpbit_s    = (op1_s == 4'h9) || (op1_s == 4'hB);
    assign dst_mem_s   = fmt1_s && instr_s[7];
    assign wb_s        = (dst_mem_s && !cmpbit_s) || (fmt2_s && (op2_s <= 3'd3) && (as_s != 2'd0));
    assign irq_s       = NMI || (IntReq && GIE);
    assign unused_bw_s = instr_s[6];

    logic       if_s, idxf_s, spf_s, ack_s, ex_s, sinc_s, rw_s, spsel_s, rd_s, wr_s;
    logic [2:0] mab_s;

    // Strobe decode and next-state selection from the current state and instruction.
    always_comb begin
        next_s  = ST_RSTV;
        if_s    = 1'b0;
        idxf_s  = 1'b0;
        spf_s   = 1'b0;
        ack_s   = 1'b0;
        ex_s    = 1'b0;
        sinc_s  = 1'b0;
        rw_s    = 1'b0;
        spsel_s = 1'b0;
        rd_s    = 1'b0;
        wr_s    = 1'b0;
        mab_s   = 3'd0;
        case (state_r)
            ST_RSTV: begin
                rd_s   = 1'b1;
                ack_s  = 1'b1;
                mab_s  = 3'd4;
                next_s = ST_FETCH;
            end
            ST_FETCH: begin
                rd_s = 1'b1;
                if (irq_s) begin
                    next_s = ST_INT_PC;
                end else begin
                    if_s = 1'b1;
                    if (has_src_s && (as_s == 2'b01)) begin
                        next_s = ST_SRC_IDX;
                    end else if (has_src_s && (as_s >= 2'd2)) begin
                        next_s = ST_SRC_RD;
                    end else if (dst_mem_s) begin
                        next_s = ST_DST_IDX;
                    end else begin
                        next_s = ST_EXEC;
                    end
                end
            end
            ST_SRC_IDX: begin
                idxf_s = 1'b1;
                rd_s   = 1'b1;
                next_s = ST_SRC_RD;
            end
            ST_SRC_RD: begin
                rd_s   = 1'b1;
                mab_s  = 3'd1;
                sinc_s = (as_s == 2'b11);
                next_s = dst_mem_s ? ST_DST_IDX : ST_EXEC;
            end
            ST_DST_IDX: begin
                idxf_s = 1'b1;
                rd_s   = 1'b1;
                next_s = (op1_s == 4'h4) ? ST_EXEC : ST_DST_RD;
            end
            ST_DST_RD: begin
                rd_s   = 1'b1;
                mab_s  = 3'd2;
                next_s = ST_EXEC;
            end
            ST_EXEC: begin
                ex_s = fmt1_s || fmt2_s || jmp_s;
                rw_s = (fmt1_s && !instr_s[7] && !cmpbit_s)
                    || (fmt2_s && (op2_s <= 3'd3) && (as_s == 2'd0))
                    || (jmp_s && JmpTaken);
                if (wb_s) begin
                    next_s = ST_WB_MEM;
                end else if (fmt2_s && ((op2_s == 3'd4) || (op2_s == 3'd5))) begin
                    next_s = ST_PUSH;
                end else if (fmt2_s && (op2_s == 3'd6)) begin
                    next_s = ST_POP_SR;
                end else begin
                    next_s = ST_FETCH;
                end
            end
            ST_WB_MEM: begin
                wr_s   = 1'b1;
                mab_s  = fmt2_s ? 3'd1 : 3'd2;
                next_s = ST_FETCH;
            end
            ST_PUSH: begin
                spf_s  = 1'b1;
                wr_s   = 1'b1;
                mab_s  = 3'd3;
                next_s = (fmt2_s && (op2_s == 3'd5)) ? ST_EXEC2 : ST_FETCH;
            end
            ST_EXEC2: begin
                ex_s   = 1'b1;
                rw_s   = 1'b1;
                next_s = ST_FETCH;
            end
            ST_POP_SR, ST_POP_PC: begin
                spsel_s = 1'b1;
                sinc_s  = 1'b1;
                rd_s    = 1'b1;
                rw_s    = 1'b1;
                mab_s   = 3'd3;
                next_s  = (state_r == ST_POP_SR) ? ST_POP_PC : ST_FETCH;
            end
            ST_INT_PC, ST_INT_SR: begin
                spf_s  = 1'b1;
                wr_s   = 1'b1;
                mab_s  = 3'd3;
                next_s = (state_r == ST_INT_PC) ? ST_INT_SR : ST_INT_VEC;
            end
            ST_INT_VEC: begin
                rd_s   = 1'b1;
                ack_s  = 1'b1;
                mab_s  = 3'd4;
                next_s = ST_FETCH;
            end
            default: begin
                next_s = ST_RSTV;
            end
        endcase
    end

    // State register and instruction latch; an interrupt-entry FETCH leaves IW untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RSTV;
            iw_r    <= 16'h0000;
        end else begin
            state_r <= next_s;
            if ((state_r == ST_FETCH) && !irq_s) begin
                iw_r <= MDB;
            end else begin
                iw_r <= iw_r;
            end
        end
    end

    // Strobes are forced low while reset is held so an abandoned writeback never reaches memory.
    assign IF     = if_s    & ~rst;
    assign IdxF   = idxf_s  & ~rst;
    assign SPF    = spf_s   & ~rst;
    assign INTACK = ack_s   & ~rst;
    assign Ex     = ex_s    & ~rst;
    assign srcInc = sinc_s  & ~rst;
    assign dstInc = 1'b0;
    assign RW     = rw_s    & ~rst;
    assign SpSel  = spsel_s & ~rst;
    assign MemRd  = rd_s    & ~rst;
    assign MemWr  = wr_s    & ~rst;
    assign MabSel = rst ? 3'd0 : mab_s;
    assign IW     = iw_r;
    assign State  = state_r;
    assign Vector = (state_r == ST_RSTV)    ? RST_VEC :
                    (state_r == ST_INT_VEC) ? ((VecAddr != 16'h0000) ? VecAddr : INT_VEC) :
                                              16'h0000;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: walks instruction sequences cycle by cycle and
// compares strobes, MAB select and state against hand-derived expectations.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst, IntReq, NMI, GIE, JmpTaken;
    logic [15:0] MDB, VecAddr;
    logic [15:0] IW, Vector;
    logic        IF, IdxF, SPF, INTACK, Ex, srcInc, dstInc, RW, SpSel, MemRd, MemWr;
    logic [2:0]  MabSel;
    logic [3:0]  State;

    int checks = 0;
    int errors = 0;

    localparam logic [10:0] B_IF = 11'h400, B_IDX = 11'h200, B_SPF = 11'h100, B_ACK = 11'h080;
    localparam logic [10:0] B_EX = 11'h040, B_SINC = 11'h020, B_RW = 11'h008;
    localparam logic [10:0] B_SPS = 11'h004, B_RD = 11'h002, B_WR = 11'h001, B_NONE = 11'h000;
    localparam logic [3:0] T_RSTV = 4'd0, T_FETCH = 4'd1, T_SRC_RD = 4'd3, T_DST_IDX = 4'd4;
    localparam logic [3:0] T_DST_RD = 4'd5, T_EXEC = 4'd6, T_WB = 4'd7, T_PUSH = 4'd8;
    localparam logic [3:0] T_EXEC2 = 4'd9, T_POP_SR = 4'd10, T_POP_PC = 4'd11;
    localparam logic [3:0] T_INT_PC = 4'd12, T_INT_SR = 4'd13, T_INT_VEC = 4'd14;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .MDB(MDB), .IntReq(IntReq), .NMI(NMI), .GIE(GIE),
        .JmpTaken(JmpTaken), .VecAddr(VecAddr), .IW(IW), .IF(IF), .IdxF(IdxF), .SPF(SPF),
        .INTACK(INTACK), .Ex(Ex), .srcInc(srcInc), .dstInc(dstInc), .RW(RW), .SpSel(SpSel),
        .MemRd(MemRd), .MemWr(MemWr), .MabSel(MabSel), .Vector(Vector), .State(State)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] snap();
        return {IF, IdxF, SPF, INTACK, Ex, srcInc, dstInc, RW, SpSel, MemRd, MemWr, MabSel, State};
    endfunction

    // Apply one cycle of inputs on the falling edge, then let combinational outputs settle.
    task automatic drive(input logic [15:0] mdb, input logic gie, irq, nmi, jmp, rs,
                         input logic [15:0] vec);
        @(negedge clk);
        MDB = mdb; GIE = gie; IntReq = irq; NMI = nmi; JmpTaken = jmp; rst = rs; VecAddr = vec;
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] exp_a [3] = '{{B_NONE, 3'd0, T_RSTV}, {B_NONE, 3'd0, T_RSTV},
                                   {B_ACK | B_RD, 3'd4, T_RSTV}};
        logic        rs_a  [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(16'h4405, 1'b0, 1'b0, 1'b0, 1'b0, rs_a[i], 16'h0000);
            checks++;
            if (snap() !== exp_a[i]) begin
                errors++;
                $display("FAIL reset step %0d: got %h expected %h", i, snap(), exp_a[i]);
            end
        end
        checks++;
        if (Vector !== 16'hFFFE) begin
            errors++;
            $display("FAIL reset_vector: got %h expected %h", Vector, 16'hFFFE);
        end
        checks++;
        if (IW !== 16'h0000) begin
            errors++;
            $display("FAIL reset_iw: got %h expected %h", IW, 16'h0000);
        end
    endtask

    task automatic test_reg_ops();
        logic [15:0] mdb_a [4] = '{16'h4405, 16'h4405, 16'h4304, 16'h4304};
        logic [17:0] exp_a [4] = '{{B_IF | B_RD, 3'd0, T_FETCH}, {B_EX | B_RW, 3'd0, T_EXEC},
                                   {B_IF | B_RD, 3'd0, T_FETCH}, {B_EX | B_RW, 3'd0, T_EXEC}};
        for (int i = 0; i < 4; i++) begin
            drive(mdb_a[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            checks++;
            if (snap() !== exp_a[i]) begin
                errors++;
                $display("FAIL reg_ops step %0d: got %h expected %h", i, snap(), exp_a[i]);
            end
            if (i == 1 || i == 3) begin
                checks++;
                if (IW !== mdb_a[i]) begin
                    errors++;
                    $display("FAIL reg_ops_iw step %0d: got %h expected %h", i, IW, mdb_a[i]);
                end
            end
        end
    endtask

    task automatic test_add_abs();
        logic [17:0] exp_a [6] = '{{B_IF | B_RD, 3'd0, T_FETCH}, {B_RD | B_SINC, 3'd1, T_SRC_RD},
                                   {B_IDX | B_RD, 3'd0, T_DST_IDX}, {B_RD, 3'd2, T_DST_RD},
                                   {B_EX, 3'd0, T_EXEC}, {B_WR, 3'd2, T_WB}};
        for (int i = 0; i < 6; i++) begin
            drive(16'h50B2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            checks++;
            if (snap() !== exp_a[i]) begin
                errors++;
                $display("FAIL add_abs step %0d: got %h expected %h", i, snap(), exp_a[i]);
            end
        end
    endtask

    task automatic test_interrupts();
        logic [15:0] mdb_a [16] = '{16'h4405, 16'h4405, 16'h1234, 16'h1234, 16'h1234, 16'h1234,
                                    16'h4405, 16'h4405, 16'h5678, 16'h5678, 16'h5678, 16'h5678,
                                    16'h4405, 16'h4405, 16'h4405, 16'h4405};
        logic [2:0]  ctl_a [16] = '{3'b100, 3'b110, 3'b110, 3'b100, 3'b100, 3'b100,
                                    3'b010, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000,
                                    3'b100, 3'b110, 3'b100, 3'b100};
        logic [15:0] vec_a [16] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                    16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC,
                                    16'h0000, 16'h0000, 16'h0000, 16'h0000};
        logic [17:0] exp_a [16] = '{{B_IF | B_RD, 3'd0, T_FETCH}, {B_EX | B_RW, 3'd0, T_EXEC},
                                    {B_RD, 3'd0, T_FETCH}, {B_SPF | B_WR, 3'd3, T_INT_PC},
                                    {B_SPF | B_WR, 3'd3, T_INT_SR}, {B_ACK | B_RD, 3'd4, T_INT_VEC},
                                    {B_IF | B_RD, 3'd0, T_FETCH}, {B_EX | B_RW, 3'd0, T_EXEC},
                                    {B_RD, 3'd0, T_FETCH}, {B_SPF | B_WR, 3'd3, T_INT_PC},
                                    {B_SPF | B_WR, 3'd3, T_INT_SR}, {B_ACK | B_RD, 3'd4, T_INT_VEC},
                                    {B_IF | B_RD, 3'd0, T_FETCH}, {B_EX | B_RW, 3'd0, T_EXEC},
                                    {B_IF | B_RD, 3'd0, T_FETCH}, {B_EX | B_RW, 3'd0, T_EXEC}};
        logic [15:0] vexp;
        for (int i = 0; i < 16; i++) begin
            drive(mdb_a[i], ctl_a[i][2], ctl_a[i][1], ctl_a[i][0], 1'b0, 1'b0, vec_a[i]);
            checks++;
            if (snap() !== exp_a[i]) begin
                errors++;
                $display("FAIL interrupts step %0d: got %h expected %h", i, snap(), exp_a[i]);
            end
            if (i == 5 || i == 11) begin
                vexp = (i == 5) ? 16'hFFF0 : 16'hFFFC;
                checks++;
                if (Vector !== vexp) begin
                    errors++;
                    $display("FAIL int_vector step %0d: got %h expected %h", i, Vector, vexp);
                end
            end
            if (i == 3 || i == 9) begin
                checks++;
                if (IW !== 16'h4405) begin
                    errors++;
                    $display("FAIL int_iw_hold step %0d: got %h expected %h", i, IW, 16'h4405);
                end
            end
        end
    endtask

    task automatic test_jump();
        logic        jmp_a [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [17:0] exp_a [4] = '{{B_IF | B_RD, 3'd0, T_FETCH}, {B_EX | B_RW, 3'd0, T_EXEC},
                                   {B_IF | B_RD, 3'd0, T_FETCH}, {B_EX, 3'd0, T_EXEC}};
        for (int i = 0; i < 4; i++) begin
            drive(16'h2001, 1'b0, 1'b0, 1'b0, jmp_a[i], 1'b0, 16'h0000);
            checks++;
            if (snap() !== exp_a[i]) begin
                errors++;
                $display("FAIL jump step %0d: got %h expected %h", i, snap(), exp_a[i]);
            end
        end
    endtask

    task automatic test_stack_and_nop();
        logic [15:0] mdb_a [10] = '{16'h1285, 16'h1285, 16'h1285, 16'h1285, 16'h1300,
                                    16'h1300, 16'h1300, 16'h1300, 16'h0000, 16'h0000};
        logic [17:0] exp_a [10] = '{{B_IF | B_RD, 3'd0, T_FETCH}, {B_EX, 3'd0, T_EXEC},
                                    {B_SPF | B_WR, 3'd3, T_PUSH}, {B_EX | B_RW, 3'd0, T_EXEC2},
                                    {B_IF | B_RD, 3'd0, T_FETCH}, {B_EX, 3'd0, T_EXEC},
                                    {B_SPS | B_SINC | B_RD | B_RW, 3'd3, T_POP_SR},
                                    {B_SPS | B_SINC | B_RD | B_RW, 3'd3, T_POP_PC},
                                    {B_IF | B_RD, 3'd0, T_FETCH}, {B_NONE, 3'd0, T_EXEC}};
        for (int i = 0; i < 10; i++) begin
            drive(mdb_a[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            checks++;
            if (snap() !== exp_a[i]) begin
                errors++;
                $display("FAIL stack_nop step %0d: got %h expected %h", i, snap(), exp_a[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic        rs_a  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [17:0] exp_a [6] = '{{B_IF | B_RD, 3'd0, T_FETCH}, {B_RD | B_SINC, 3'd1, T_SRC_RD},
                                   {B_IDX | B_RD, 3'd0, T_DST_IDX}, {B_NONE, 3'd0, T_DST_RD},
                                   {B_ACK | B_RD, 3'd4, T_RSTV}, {B_IF | B_RD, 3'd0, T_FETCH}};
        for (int i = 0; i < 6; i++) begin
            drive(16'h50B2, 1'b0, 1'b0, 1'b0, 1'b0, rs_a[i], 16'h0000);
            checks++;
            if (snap() !== exp_a[i]) begin
                errors++;
                $display("FAIL reset_midflight step %0d: got %h expected %h", i, snap(), exp_a[i]);
            end
            if (i == 4) begin
                checks++;
                if (IW !== 16'h0000) begin
                    errors++;
                    $display("FAIL reset_midflight_iw: got %h expected %h", IW, 16'h0000);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; MDB = 16'h0000; IntReq = 1'b0; NMI = 1'b0; GIE = 1'b0;
        JmpTaken = 1'b0; VecAddr = 16'h0000;
        test_reset();
        test_reg_ops();
        test_add_abs();
        test_interrupts();
        test_jump();
        test_stack_and_nop();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
